// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered-output ALU among NREQ requesters,
// with valid/ready handshakes on both the request and response sides.
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [3*NREQ-1:0]    i_req_funct3,
    input  logic [NREQ-1:0]      i_req_alt,
    input  logic [32*NREQ-1:0]   i_req_x,
    input  logic [32*NREQ-1:0]   i_req_y,
    output logic [NREQ-1:0]      o_rsp_valid,
    input  logic [NREQ-1:0]      i_rsp_ready,
    output logic [31:0]          o_rsp_data,
    output logic [2:0]           o_alu_funct3,
    output logic                 o_alu_alt,
    output logic [31:0]          o_alu_x,
    output logic [31:0]          o_alu_y,
    input  logic [31:0]          i_alu_out
);

    localparam int IW = $clog2(NREQ);

    typedef struct packed {
        logic [2:0]  funct3;
        logic        alt;
        logic [31:0] x;
        logic [31:0] y;
    } op_t;

    logic          r_busy;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_ptr;
    op_t           r_held;

    logic          w_found;
    logic          w_consume;
    logic          w_can_issue;
    logic          w_issue;
    logic [IW-1:0] w_grant;
    op_t           w_req_op;
    op_t           w_alu_op;

    always_comb begin
        o_rsp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            o_rsp_valid[i] = r_busy && (r_owner == IW'(i));
    end

    assign w_consume   = o_rsp_valid[r_owner] && i_rsp_ready[r_owner];
    assign w_can_issue = !i_reset && (!r_busy || w_consume);
    assign w_issue     = w_found && w_can_issue;

    // Two passes give wrap-around priority: indices at or above ptr first, then the rest.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req_valid[i] && (IW'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_grant = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req_valid[i]) begin
                w_found = 1'b1;
                w_grant = IW'(i);
            end
        end
    end

    always_comb begin
        w_req_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IW'(i)) begin
                w_req_op.funct3 = i_req_funct3[3*i +: 3];
                w_req_op.alt    = i_req_alt[i];
                w_req_op.x      = i_req_x[32*i +: 32];
                w_req_op.y      = i_req_y[32*i +: 32];
            end
        end
    end

    // Re-driving the held op keeps the registered ALU output stable while a result waits.
    always_comb begin
        if (i_reset)
            w_alu_op = '0;
        else if (w_issue)
            w_alu_op = w_req_op;
        else
            w_alu_op = r_held;
    end

    always_comb begin
        o_req_ready = '0;
        if (w_issue)
            o_req_ready[w_grant] = 1'b1;
    end

    assign o_alu_funct3 = w_alu_op.funct3;
    assign o_alu_alt    = w_alu_op.alt;
    assign o_alu_x      = w_alu_op.x;
    assign o_alu_y      = w_alu_op.y;
    assign o_rsp_data   = i_alu_out;

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_held  <= '0;
        end else if (w_issue) begin
            r_busy  <= 1'b1;
            r_owner <= w_grant;
            r_held  <= w_req_op;
            r_ptr   <= (w_grant == IW'(NREQ-1)) ? '0 : w_grant + IW'(1);
        end else if (w_consume) begin
            r_busy  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed results, a
// negedge monitor compares every presented response against the queue head.
module tb_alu_arbiter;

    localparam int NREQ = 4;

    typedef struct {
        int          owner;
        logic [31:0] data;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_alt;
    logic [3*NREQ-1:0]   req_funct3;
    logic [32*NREQ-1:0]  req_x;
    logic [32*NREQ-1:0]  req_y;
    logic [NREQ-1:0]     rsp_ready;
    logic [31:0]         alu_out;

    logic [NREQ-1:0]     o_req_ready;
    logic [NREQ-1:0]     o_rsp_valid;
    logic [31:0]         o_rsp_data;
    logic [2:0]          o_alu_funct3;
    logic                o_alu_alt;
    logic [31:0]         o_alu_x;
    logic [31:0]         o_alu_y;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 0;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_funct3 (req_funct3),
        .i_req_alt    (req_alt),
        .i_req_x      (req_x),
        .i_req_y      (req_y),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_alu_funct3 (o_alu_funct3),
        .o_alu_alt    (o_alu_alt),
        .o_alu_x      (o_alu_x),
        .o_alu_y      (o_alu_y),
        .i_alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU with a registered output and no reset, as it sits outside the arbiter.
    function automatic logic [31:0] alu_f(input logic [2:0] f, input logic a, input logic [31:0] x, input logic [31:0] y);
        case (f)
            3'd0:    return a ? x - y : x + y;
            3'd1:    return x << y[4:0];
            3'd2:    return {31'b0, $signed(x) < $signed(y)};
            3'd3:    return {31'b0, x < y};
            3'd4:    return x ^ y;
            3'd5:    return a ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    always_ff @(posedge clk) alu_out <= alu_f(o_alu_funct3, o_alu_alt, o_alu_x, o_alu_y);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [2:0] f, input logic a, input logic [31:0] x, input logic [31:0] y);
        req_funct3[3*i +: 3] = f;
        req_alt[i]           = a;
        req_x[32*i +: 32]    = x;
        req_y[32*i +: 32]    = y;
    endtask

    // One cycle with inputs already driven; a nonzero expected grant pushes the expected result.
    task automatic step(input logic [NREQ-1:0] exp_rdy, input int own, input logic [31:0] dat);
        @(negedge clk);
        check("req_ready", 32'(o_req_ready), 32'(exp_rdy));
        if (exp_rdy != '0) sb.push_back('{owner: own, data: dat});
        @(posedge clk);
        #1;
    endtask

    task automatic hold_cyc(input logic [NREQ-1:0] exp_rv, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        check("req_ready_idle", 32'(o_req_ready), 32'd0);
        check("rsp_valid_idle", 32'(o_rsp_valid), 32'(exp_rv));
        check("alu_ctl_hold", 32'({o_alu_funct3, o_alu_alt}), 32'({f, 1'b0}));
        check("alu_x_hold", o_alu_x, x);
        check("alu_y_hold", o_alu_y, y);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0001;
        rsp_ready = '0;
        @(negedge clk);
        check("reset_req_ready", 32'(o_req_ready), 32'd0);
        check("reset_alu_x", o_alu_x, 32'd0);
        check("reset_alu_y", o_alu_y, 32'd0);
        check("reset_alu_ctl", 32'({o_alu_funct3, o_alu_alt}), 32'd0);
        @(posedge clk);
        #1;
        sb.delete();
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        @(negedge clk);
        check("post_reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && o_rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, expected no response", o_rsp_valid, o_rsp_data);
                end else begin
                    check("rsp_valid", 32'(o_rsp_valid), 32'(1) << sb[0].owner);
                    check("rsp_data", o_rsp_data, sb[0].data);
                    if ((o_rsp_valid & rsp_ready) != '0) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        req_alt = '0; req_funct3 = '0; req_x = '0; req_y = '0;
        set_op(0, 3'b000, 1'b0, 32'd5, 32'd7);
        do_reset();
        mon_en = 1'b1;

        // Single op: ADD 5+7
        set_op(0, 3'b000, 1'b0, 32'd5, 32'd7);
        req_valid = 4'b0001; rsp_ready = '1;
        step(4'b0001, 0, 32'd12);
        req_valid = '0;
        step(4'b0000, 0, 32'd0);
        do_reset();

        // Contention: grants alternate 0,1,0,1
        set_op(0, 3'b000, 1'b1, 32'd10, 32'd3);
        set_op(1, 3'b100, 1'b0, 32'h0000_00F0, 32'h0000_000F);
        req_valid = 4'b0011; rsp_ready = '1;
        step(4'b0001, 0, 32'd7);
        step(4'b0010, 1, 32'hFF);
        step(4'b0001, 0, 32'd7);
        step(4'b0010, 1, 32'hFF);
        req_valid = '0;
        step(4'b0000, 0, 32'd0);

        // Backpressure: SLT held three cycles, req0 issues on consume
        set_op(1, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1);
        set_op(0, 3'b000, 1'b0, 32'd100, 32'd23);
        req_valid = 4'b0010;
        step(4'b0010, 1, 32'd1);
        req_valid = 4'b0001; rsp_ready = 4'b1101;
        for (int i = 0; i < 3; i++) step(4'b0000, 0, 32'd0);
        rsp_ready = '1;
        step(4'b0001, 0, 32'd123);
        req_valid = '0;
        step(4'b0000, 0, 32'd0);

        // Shift right arithmetic then logical, same owner back to back
        set_op(0, 3'b101, 1'b1, 32'h8000_0000, 32'd4);
        req_valid = 4'b0001;
        step(4'b0001, 0, 32'hF800_0000);
        set_op(0, 3'b101, 1'b0, 32'h8000_0000, 32'd4);
        step(4'b0001, 0, 32'h0800_0000);
        req_valid = '0;
        step(4'b0000, 0, 32'd0);

        // Reset in the response cycle discards the result
        set_op(0, 3'b001, 1'b0, 32'd1, 32'd31);
        req_valid = 4'b0001;
        step(4'b0001, 0, 32'h8000_0000);
        do_reset();
        set_op(0, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        set_op(1, 3'b110, 1'b0, 32'h0000_1200, 32'h0000_0034);
        req_valid = 4'b0011;
        step(4'b0001, 0, 32'h0F00_0F00);
        req_valid = 4'b0010;
        step(4'b0010, 1, 32'h0000_1234);
        req_valid = '0;
        step(4'b0000, 0, 32'd0);

        // Stability: req3 alone, ptr wraps, idle cycles hold everything
        set_op(3, 3'b011, 1'b0, 32'd1, 32'hFFFF_FFFF);
        req_valid = 4'b1000;
        step(4'b1000, 3, 32'd1);
        req_valid = '0; rsp_ready = 4'b0111;
        for (int i = 0; i < 3; i++) hold_cyc(4'b1000, 3'b011, 32'd1, 32'hFFFF_FFFF);
        rsp_ready = '1;
        hold_cyc(4'b1000, 3'b011, 32'd1, 32'hFFFF_FFFF);
        for (int i = 0; i < 2; i++) hold_cyc(4'b0000, 3'b011, 32'd1, 32'hFFFF_FFFF);
        set_op(0, 3'b000, 1'b0, 32'd2, 32'd2);
        set_op(2, 3'b000, 1'b0, 32'd3, 32'd3);
        req_valid = 4'b1101;
        step(4'b0001, 0, 32'd4);
        req_valid = 4'b1100;
        step(4'b0100, 2, 32'd6);
        req_valid = '0;
        step(4'b0000, 0, 32'd0);
        step(4'b0000, 0, 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
